// File: rtl/aes_enc_iter_128.sv
// ----------------------------------------------------------------------------
// aes_enc_iter_128
//
// Iterative AES-128 encryption core. It performs one cipher round per clock
// and uses the 11 round keys from an external static key schedule.
//
// Handshakes (both directions): a transfer happens on the rising edge where
// valid and ready are both high. A producer holds valid and data stable until
// that edge. ready never depends combinationally on valid; both ready and
// valid come straight from the FSM state register.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rks_i        round keys, key i at rks_i[128*i +: 128]; stable while busy
//   pt_i         plaintext, bits [127:120] = byte 0, column-major state
//   pt_valid_i   plaintext valid
//   pt_ready_o   core idle, plaintext can be accepted
//   ct_o         ciphertext (same byte order as pt_i), held after handshake
//   ct_valid_o   ciphertext valid
//   ct_ready_i   downstream accepts ciphertext
//   busy_o       encryption in progress or result waiting
//   dbg_state_o  FSM state (0 idle, 1 round, 2 done)
//   dbg_round_o  round counter
//   dbg_st_o     cipher state register
// ----------------------------------------------------------------------------
module aes_enc_iter_128 #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [128*(NR+1)-1:0] rks_i,
    input  logic [127:0]          pt_i,
    input  logic                  pt_valid_i,
    output logic                  pt_ready_o,
    output logic [127:0]          ct_o,
    output logic                  ct_valid_o,
    input  logic                  ct_ready_i,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o,
    output logic [3:0]            dbg_round_o,
    output logic [127:0]          dbg_st_o
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_enc_iter_128: only NR = 10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: byte (row r, col c) lives at bit
    // 127-8*(r+4c); ShiftRows takes row r from column (c+r) mod 4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_t       r_state;
    logic [3:0]   r_round;
    logic [127:0] r_st;
    logic [127:0] r_ct;

    logic [127:0] w_rk;
    logic [127:0] w_sr;
    logic [127:0] w_mid_round;
    logic [127:0] w_last_round;

    // Round key for the current round. Out-of-range counter values select
    // zero; the FSM aborts on them anyway.
    always_comb begin
        w_rk = '0;
        for (int i = 1; i <= NR; i++) begin
            if (r_round == 4'(i)) begin
                w_rk = rks_i[128*i +: 128];
            end
        end
    end

    assign w_sr         = sub_shift(r_st);
    assign w_mid_round  = mix_columns(w_sr) ^ w_rk;
    assign w_last_round = w_sr ^ w_rk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_st    <= '0;
            r_ct    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pt_valid_i) begin
                        r_st    <= pt_i ^ rks_i[127:0];
                        r_round <= 4'd1;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_round == 4'd0 || r_round > NR4) begin
                        // Corrupted counter: drop the block.
                        r_round <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_round < NR4) begin
                        r_st    <= w_mid_round;
                        r_round <= r_round + 4'd1;
                    end else begin
                        // Final round skips MixColumns; counter stays at NR.
                        r_st    <= w_last_round;
                        r_ct    <= w_last_round;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ct_ready_i) begin
                        r_round <= 4'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_round <= 4'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pt_ready_o  = (r_state == S_IDLE);
    assign ct_valid_o  = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign ct_o        = r_ct;
    assign dbg_state_o = r_state;
    assign dbg_round_o = r_round;
    assign dbg_st_o    = r_st;

endmodule

// File: tb/tb_aes_enc_iter_128.sv
// ----------------------------------------------------------------------------
// tb_aes_enc_iter_128
//
// Self-checking bench for aes_enc_iter_128. The reference model works on a
// 4x4 byte matrix, builds its S-box from GF(2^8) inverses plus the affine
// map, and expands keys itself. Expected ciphertexts go into exp_q at accept
// time and are popped at the ciphertext handshake.
// ----------------------------------------------------------------------------
module tb_aes_enc_iter_128;

  logic           clk = 1'b0;
  logic           rst;
  logic [1407:0]  rks_i;
  logic [127:0]   pt_i;
  logic           pt_valid_i;
  logic           pt_ready_o;
  logic [127:0]   ct_o;
  logic           ct_valid_o;
  logic           ct_ready_i;
  logic           busy_o;
  logic [1:0]     dbg_state_o;
  logic [3:0]     dbg_round_o;
  logic [127:0]   dbg_st_o;

  aes_enc_iter_128 #(.NR(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .rks_i       (rks_i),
    .pt_i        (pt_i),
    .pt_valid_i  (pt_valid_i),
    .pt_ready_o  (pt_ready_o),
    .ct_o        (ct_o),
    .ct_valid_o  (ct_valid_o),
    .ct_ready_i  (ct_ready_i),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o),
    .dbg_round_o (dbg_round_o),
    .dbg_st_o    (dbg_st_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   ref_sb[256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      if (v != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      ref_sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w[44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sb[t[31:24]], ref_sb[t[23:16]], ref_sb[t[15:8]], ref_sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // Encrypt through round 'last' (10 = full cipher).
  function automatic logic [127:0] aes_ref(input logic [1407:0] rks, input logic [127:0] pt, input int last);
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [127:0] out;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ rks[127-8*(r+4*c) -: 8];
    for (int rnd = 1; rnd <= last; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = ref_sb[s[(r)][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ rks[128*rnd + 127 - 8*(r+4*c) -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127-8*(r+4*c) -: 8] = s[r][c];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_pt(input logic [127:0] pt);
    bit ok;
    bit rdy;
    ok = 0;
    pt_i = pt;
    pt_valid_i = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = pt_ready_o;
      tick();
      if (rdy) ok = 1;
    end
    pt_valid_i = 1'b0;
    pt_i = rand128();
    chk("accept", 128'(ok), 128'd1);
    exp_q.push_back(aes_ref(rks_i, pt, 10));
  endtask

  // Latency counts edges from the accept edge (1) up to and including the
  // edge that raises ct_valid_o.
  task automatic wait_ct(input bit chk_r1, input logic [127:0] r1_exp, output int lat);
    bit seen;
    seen = 0;
    lat = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ct_valid_o === 1'b1) begin
        seen = 1;
      end else begin
        ct_ready_i = 1'($urandom_range(0, 1));
        tick();
        lat++;
        if (chk_r1 && lat == 2) chk("round1_state", dbg_st_o, r1_exp);
      end
    end
    ct_ready_i = 1'b0;
    chk("ct_valid_seen", 128'(seen), 128'd1);
  endtask

  task automatic take_ct(input int hold, output logic [127:0] got);
    logic [127:0] exp;
    bit stable;
    bit rdy_low;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'bx;
    got = ct_o;
    stable = 1;
    rdy_low = (pt_ready_o === 1'b0 && busy_o === 1'b1);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (ct_o !== got || ct_valid_o !== 1'b1) stable = 0;
      if (pt_ready_o !== 1'b0 || busy_o !== 1'b1) rdy_low = 0;
    end
    chk("ct_value", got, exp);
    chk("ready_low_in_done", 128'(rdy_low), 128'd1);
    if (hold > 0) chk("ct_stable", 128'(stable), 128'd1);
    ct_ready_i = 1'b1;
    tick();
    ct_ready_i = 1'b0;
    chk("post_hs_valid", 128'(ct_valid_o), 128'd0);
    chk("post_hs_ready", 128'(pt_ready_o), 128'd1);
    chk("post_hs_ct_hold", ct_o, exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int           lat;
    logic [127:0] got;
    logic [127:0] pa, pb, cur_pt;
    int           acc_cyc[2];
    int           n_acc, n_ct, cyc;
    bit           rdy, vld, ctv, never, bad_v, bad_o, bad_b;

    rst = 1'b1;
    rks_i = '0;
    pt_i = '0;
    pt_valid_i = 1'b0;
    ct_ready_i = 1'b0;
    build_sbox();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pt_ready", 128'(pt_ready_o), 128'd1);
    chk("rst_ct_valid", 128'(ct_valid_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_ct", ct_o, 128'd0);
    chk("rst_st", dbg_st_o, 128'd0);

    // FIPS-197 C.1 with latency
    rks_i = key_expand(128'h000102030405060708090a0b0c0d0e0f);
    send_pt(128'h00112233445566778899aabbccddeeff);
    wait_ct(1'b0, 128'd0, lat);
    chk("c1_latency", 128'(lat), 128'd11);
    take_ct(2, got);
    chk("c1_ct", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // FIPS-197 B with round-1 intermediate
    rks_i = key_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send_pt(128'h3243f6a8885a308d313198a2e0370734);
    wait_ct(1'b1, 128'ha49c7ff2689f352b6b5bea43026a5049, lat);
    take_ct(0, got);
    chk("b_ct", got, 128'h3925841d02dc09fbdc118597196a0b32);

    // Backpressure: 20 cycles of ct_ready_i low
    send_pt(128'h6bc1bee22e409f96e93d7e117393172a);
    wait_ct(1'b0, 128'd0, lat);
    take_ct(20, got);
    chk("bp_ct", got, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

    // Back-to-back with pt_valid_i held high
    rks_i = key_expand(rand128());
    pa = rand128();
    pb = rand128();
    pt_i = pa;
    pt_valid_i = 1'b1;
    ct_ready_i = 1'b1;
    n_acc = 0;
    n_ct = 0;
    cyc = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    for (int i = 0; i < 80 && n_ct < 2; i++) begin
      rdy = pt_ready_o;
      vld = pt_valid_i;
      ctv = ct_valid_o;
      cur_pt = pt_i;
      if (ctv) begin
        chk("b2b_ct", ct_o, (exp_q.size() > 0) ? exp_q.pop_front() : 128'bx);
        n_ct++;
      end
      tick();
      cyc++;
      if (rdy && vld) begin
        acc_cyc[n_acc] = cyc;
        exp_q.push_back(aes_ref(rks_i, cur_pt, 10));
        n_acc++;
        pt_i = rand128();
        if (n_acc == 2) pt_valid_i = 1'b0;
      end
      // second block appears mid-flight; the garbage before it is ignored
      if (n_acc == 1 && cyc == acc_cyc[0] + 5) pt_i = pb;
    end
    ct_ready_i = 1'b0;
    pt_valid_i = 1'b0;
    chk("b2b_count", 128'(n_ct), 128'd2);
    chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);

    // Random keys and plaintexts
    for (int k = 0; k < 6; k++) begin
      rks_i = key_expand(rand128());
      send_pt(rand128());
      wait_ct(1'b0, 128'd0, lat);
      take_ct(int'($urandom_range(0, 3)), got);
    end

    // Reset during round 5
    rks_i = key_expand(128'h000102030405060708090a0b0c0d0e0f);
    send_pt(rand128());
    for (int i = 0; i < 4; i++) tick();
    chk("abort_round", 128'(dbg_round_o), 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_pt_ready", 128'(pt_ready_o), 128'd1);
    chk("abort_ct_valid", 128'(ct_valid_o), 128'd0);
    chk("abort_busy", 128'(busy_o), 128'd0);
    chk("abort_ct", ct_o, 128'd0);
    exp_q.delete();
    never = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ct_valid_o !== 1'b0) never = 0;
    end
    chk("abort_no_ct", 128'(never), 128'd1);
    send_pt(128'h00112233445566778899aabbccddeeff);
    wait_ct(1'b0, 128'd0, lat);
    take_ct(1, got);
    chk("abort_c1_ct", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Post-reset idle with ct_ready_i toggling
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad_v = 0;
    bad_o = 0;
    bad_b = 0;
    for (int i = 0; i < 50; i++) begin
      ct_ready_i = 1'($urandom_range(0, 1));
      tick();
      if (ct_valid_o !== 1'b0) bad_v = 1;
      if (ct_o !== 128'd0) bad_o = 1;
      if (busy_o !== 1'b0) bad_b = 1;
    end
    ct_ready_i = 1'b0;
    chk("idle_ct_valid", 128'(bad_v), 128'd0);
    chk("idle_ct_zero", 128'(bad_o), 128'd0);
    chk("idle_busy", 128'(bad_b), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
